sdram_line_fetcher: RTL

Avalon-MM read master that drives the SDRAM controller's `sdram_mm` slave port from fabric logic. It fetches a run of consecutive 32-bit words (one sprite row or scanline) and presents them on a ready/valid stream for the sprite/VGA pipeline. Reads are pipelined, and an internal FIFO sized against outstanding requests guarantees that `readdatavalid` data is never dropped.

---
 rtl/sdram_line_fetcher.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sdram_line_fetcher.sv
// Avalon-MM pipelined read master: fetches a run of consecutive SDRAM words
// and streams them through a credit-protected FIFO onto a ready/valid port.
module sdram_line_fetcher #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [24:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [24:0]      sdram_mm_address,
    output logic [3:0]       sdram_mm_byteenable_n,
    output logic             sdram_mm_chipselect,
    output logic [31:0]      sdram_mm_writedata,
    output logic             sdram_mm_read_n,
    output logic             sdram_mm_write_n,
    input  logic [31:0]      sdram_mm_readdata,
    input  logic             sdram_mm_readdatavalid,
    input  logic             sdram_mm_waitrequest,
    output logic [31:0]      pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             done
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;

    logic [24:0]      addr;
    logic [CNT_W-1:0] remaining, rx_left, rx_left_nx;
    logic [PW-1:0]    pending, pending_nx, stale, fifo_count, fifo_count_nx;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [31:0]      mem [FIFO_DEPTH];
    logic             cs, read_n, done_r, ovf;
    logic             acc, beat, beat_stale, start_ok, pop, full, push_ok;
    logic             cs_nx, done_nx;
    logic [PW1-1:0]   credit_sum, stale_sum;

    // Reads still in flight when Reset hit are counted in 'stale' and their
    // beats are swallowed, so they never reach the FIFO or the new counters.
    assign acc        = cs & ~sdram_mm_waitrequest;
    assign beat       = sdram_mm_readdatavalid & (stale == '0);
    assign beat_stale = sdram_mm_readdatavalid & (stale != '0);
    assign start_ok   = (state == IDLE) & start & ~done_r & (stale == '0);

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == PW'(FIFO_DEPTH));
    assign pix_valid  = (fifo_count != '0);
    assign pix_data   = mem[rd_ptr[AW-1:0]];
    assign pop        = pix_valid & pix_ready;
    assign push_ok    = beat & (~full | pop);

    assign rx_left_nx    = rx_left - CNT_W'(beat);
    assign pending_nx    = pending + PW'(acc) - PW'(beat);
    assign fifo_count_nx = fifo_count + PW'(push_ok) - PW'(pop);
    assign credit_sum    = {1'b0, pending_nx} + {1'b0, fifo_count_nx};
    assign stale_sum     = {1'b0, stale} + {1'b0, pending} + PW1'(acc);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok && word_count != '0) state_nx = ISSUE;
            ISSUE:   if (acc && remaining == CNT_W'(1)) state_nx = DRAIN;
            DRAIN:   if (rx_left_nx == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered, so the credit check looks at next-cycle counts.
    always_comb begin
        cs_nx   = (state_nx == ISSUE) && (credit_sum < PW1'(FIFO_DEPTH));
        done_nx = ((state == DRAIN) && (rx_left_nx == '0)) ||
                  (start_ok && (word_count == '0));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cs        <= 1'b0;
            read_n    <= 1'b1;
            addr      <= '0;
            remaining <= '0;
            rx_left   <= '0;
            pending   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            done_r    <= 1'b0;
            ovf       <= 1'b0;
            stale     <= (stale_sum == '0) ? '0 :
                         PW'(stale_sum - PW1'(sdram_mm_readdatavalid));
        end else begin
            cs      <= cs_nx;
            read_n  <= ~cs_nx;
            done_r  <= done_nx;
            pending <= pending_nx;
            if (beat_stale) stale <= stale - PW'(1);
            if (start_ok && word_count != '0) begin
                addr      <= base_addr;
                remaining <= word_count;
                rx_left   <= word_count;
            end else begin
                if (acc) begin
                    addr      <= addr + 25'd1;
                    remaining <= remaining - CNT_W'(1);
                end
                rx_left <= rx_left_nx;
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (beat && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= sdram_mm_readdata;
    end

    assert property (@(posedge Clk) disable iff (Reset) !ovf);

    assign sdram_mm_address      = addr;
    assign sdram_mm_chipselect   = cs;
    assign sdram_mm_read_n       = read_n;
    assign sdram_mm_byteenable_n = 4'b0000;
    assign sdram_mm_writedata    = 32'd0;
    assign sdram_mm_write_n      = 1'b1;
    assign busy                  = (state != IDLE);
    assign done                  = done_r;
endmodule
